// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: funct codes, FSM states
// and funct decode helpers.
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    // Any instruction that touches HI/LO or starts the datapath.
    function automatic logic is_muldiv(input logic [5:0] funct);
        return funct inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                             FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction

    // Instructions that launch an iterative operation.
    function automatic logic is_arith(input logic [5:0] funct);
        return funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {acc, q}: shift-add multiply (mode=0) or
// restoring divide (mode=1). Purely combinational.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
    // acc < b always holds, so the extra bit keeps the shifted remainder exact
    assign shifted = {acc, q[WIDTH-1]};
    assign diff    = shifted - {1'b0, b};

    always_comb begin
        acc_nxt = '0;
        q_nxt   = '0;
        if (mode) begin
            if (diff[WIDTH]) begin
                acc_nxt = shifted[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = diff[WIDTH-1:0];
                q_nxt   = {q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_nxt = sum[WIDTH:1];
            q_nxt   = {sum[0], q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO, with pipeline stall.
// Optional macro MULDIV_EARLY_OUT_EN: multiply exits once remaining multiplier bits are zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] mf_data
);

    state_t state, state_nxt;

    logic [WIDTH-1:0]   hi, lo, acc, q, b;
    logic [CNT_W-1:0]   count;
    logic               is_div, neg_res, neg_rem, dz_pend, div_zero_q;

    logic               op_div, op_signed, sign1, sign2, zero_div, start;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH-1:0]   acc_step, q_step, acc_calc, q_calc;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic               early_out;

    assign op_div    = funct[1];
    assign op_signed = ~funct[0];
    assign sign1     = op_signed & reg1[WIDTH-1];
    assign sign2     = op_signed & reg2[WIDTH-1];
    assign abs1      = sign1 ? -reg1 : reg1;
    assign abs2      = sign2 ? -reg2 : reg2;
    assign zero_div  = op_div && (reg2 == '0);
    assign start     = (state == IDLE) && valid && !flush && is_arith(funct);

    assign prod     = {acc, q};
    assign prod_neg = -prod;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode    (is_div),
        .acc     (acc),
        .q       (q),
        .b       (b),
        .acc_nxt (acc_step),
        .q_nxt   (q_step)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]   remain_mask;
    logic [2*WIDTH-1:0] prod_early;

    // The low `count` bits of q are the multiplier bits not yet consumed; once
    // they are zero, the remaining iterations would only shift right.
    assign remain_mask = ~({WIDTH{1'b1}} << count);
    assign early_out   = !is_div && ((q & remain_mask) == '0);
    assign prod_early  = {acc, q} >> count;
    assign {acc_calc, q_calc} = early_out ? prod_early : {acc_step, q_step};
`else
    assign early_out = 1'b0;
    assign acc_calc  = acc_step;
    assign q_calc    = q_step;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_div ? FIXUP : CALC;
            CALC: begin
                if (flush)
                    state_nxt = IDLE;
                else if (count == CNT_W'(1) || early_out)
                    state_nxt = FIXUP;
            end
            FIXUP:   state_nxt = flush ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi         <= '0;
            lo         <= '0;
            acc        <= '0;
            q          <= '0;
            b          <= '0;
            count      <= '0;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            dz_pend    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count   <= CNT_W'(WIDTH);
                        is_div  <= op_div;
                        acc     <= '0;
                        neg_res <= sign1 ^ sign2;
                        neg_rem <= sign1 & op_div;
                        dz_pend <= zero_div;
                        if (op_div) begin
                            q <= zero_div ? reg1 : abs1;
                            b <= abs2;
                            if (!zero_div) div_zero_q <= 1'b0;
                        end else begin
                            q <= abs2;
                            b <= abs1;
                        end
                    end else if (valid && funct == FUNCT_MTHI) begin
                        hi <= reg1;
                    end else if (valid && funct == FUNCT_MTLO) begin
                        lo <= reg1;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc   <= acc_calc;
                        q     <= q_calc;
                        count <= count - CNT_W'(1);
                    end
                end
                FIXUP: begin
                    if (!flush) begin
                        if (dz_pend) begin
                            hi         <= q;
                            lo         <= '1;
                            div_zero_q <= 1'b1;
                        end else if (is_div) begin
                            lo <= neg_res ? -q : q;
                            hi <= neg_rem ? -acc : acc;
                        end else begin
                            {hi, lo} <= neg_res ? prod_neg : prod;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign stall    = valid && busy && is_muldiv(funct);
    assign div_zero = div_zero_q;
    assign mf_data  = (funct == FUNCT_MFHI) ? hi : lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected HI/LO/div_zero
// computed from a wide-arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, valid, flush;
    logic [5:0]   funct;
    logic [W-1:0] reg1, reg2;
    logic         stall, busy, done, div_zero;
    logic [W-1:0] mf_data;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .funct    (funct),
        .reg1     (reg1),
        .reg2     (reg2),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .mf_data  (mf_data)
    );

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    logic dz_model;
    int   checks, passed;

    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] d, input logic dz_in);
        exp_t        e;
        longint      sa, sd, sq, sr;
        logic [63:0] v, vr;
        e.hi = '0; e.lo = '0; e.dz = dz_in;
        sa = longint'($signed(a));
        sd = longint'($signed(d));
        case (f)
            FUNCT_MULT: begin
                v = 64'(sa * sd);
                e.hi = v[63:32]; e.lo = v[31:0];
            end
            FUNCT_MULTU: begin
                v = {32'b0, a} * {32'b0, d};
                e.hi = v[63:32]; e.lo = v[31:0];
            end
            default: begin
                if (d == '0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (f == FUNCT_DIV) begin
                    sq = sa / sd; sr = sa % sd;
                    v = 64'(sq); vr = 64'(sr);
                    e.lo = v[31:0]; e.hi = vr[31:0]; e.dz = 1'b0;
                end else begin
                    e.lo = a / d; e.hi = a % d; e.dz = 1'b0;
                end
            end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] d);
        exp_t e;
        @(negedge clk);
        valid = 1'b1; funct = f; reg1 = a; reg2 = d;
        e = model(f, a, d, dz_model);
        dz_model = e.dz;
        sb.push_back(e);
        @(posedge clk); #1;
        valid = 1'b0; funct = 6'h00;
    endtask

    // lat counts clock edges from the start edge (inclusive) to the edge after which done is seen.
    task automatic wait_done(output int lat, output bit to);
        lat = 1; to = 1'b0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            if (lat >= 60) begin to = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l, output logic st);
        @(negedge clk);
        valid = 1'b1; funct = FUNCT_MFHI; #1;
        h = mf_data; st = stall;
        funct = FUNCT_MFLO; #1;
        l = mf_data; st = st | stall;
        valid = 1'b0; funct = 6'h00;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        valid = 1'b1; funct = FUNCT_MULT; reg1 = 32'd5; reg2 = 32'd6;
        @(posedge clk); #1;
        checks++;
        if ({busy, stall, done, div_zero} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy, stall, done, div_zero});
        else passed++;
        funct = FUNCT_MFHI; #1;
        checks++;
        if (mf_data !== '0) $display("FAIL reset_hi got %h want 0", mf_data); else passed++;
        funct = FUNCT_MFLO; #1;
        checks++;
        if (mf_data !== '0) $display("FAIL reset_lo got %h want 0", mf_data); else passed++;
        @(negedge clk);
        valid = 1'b0; funct = 6'h00; reset = 1'b1;
    endtask

    task automatic test_mult;
        logic [5:0]   fs[7];
        logic [W-1:0] as[7], ds[7], h, l;
        logic         st, ok;
        int           lat;
        bit           to;
        exp_t         e;
        fs = '{FUNCT_MULT, FUNCT_MULT, FUNCT_MULTU, FUNCT_MULT, FUNCT_MULTU, FUNCT_MULT, FUNCT_MULT};
        as = '{32'hFFFFFFFD, 32'h80000000, $urandom(), $urandom(), 32'h00000000, 32'd12345, $urandom()};
        ds = '{32'd7, 32'h80000000, $urandom(), $urandom(), 32'h89ABCDEF, 32'hFFFFFFFF, $urandom()};
        for (int i = 0; i < 7; i++) begin
            issue(fs[i], as[i], ds[i]);
            wait_done(lat, to);
            read_hilo(h, l, st);
            e = sb.pop_front();
`ifdef MULDIV_EARLY_OUT_EN
            ok = !to && (lat <= 34);
`else
            ok = !to && (lat == 34);
`endif
            checks++;
            if (!ok) $display("FAIL mult%0d_latency got %0d (timeout=%0b) want 34", i, lat, to); else passed++;
            checks++;
            if (h !== e.hi) $display("FAIL mult%0d_hi got %h want %h", i, h, e.hi); else passed++;
            checks++;
            if (l !== e.lo) $display("FAIL mult%0d_lo got %h want %h", i, l, e.lo); else passed++;
        end
    endtask

    task automatic test_div;
        logic [5:0]   fs[7];
        logic [W-1:0] as[7], ds[7], h, l;
        logic         st;
        int           lat;
        bit           to;
        exp_t         e;
        fs = '{FUNCT_DIVU, FUNCT_DIV, FUNCT_DIV, FUNCT_DIV, FUNCT_DIVU, FUNCT_DIV, FUNCT_DIVU};
        as = '{32'd100, 32'hFFFFFF9C, 32'h80000000, 32'd7, 32'hFFFFFFFF, $urandom(), $urandom()};
        ds = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'($urandom_range(1, 1000)), $urandom() | 32'h1};
        for (int i = 0; i < 7; i++) begin
            issue(fs[i], as[i], ds[i]);
            wait_done(lat, to);
            read_hilo(h, l, st);
            e = sb.pop_front();
            checks++;
            if (to || lat != 34) $display("FAIL div%0d_latency got %0d (timeout=%0b) want 34", i, lat, to); else passed++;
            checks++;
            if (l !== e.lo) $display("FAIL div%0d_quotient got %h want %h", i, l, e.lo); else passed++;
            checks++;
            if (h !== e.hi) $display("FAIL div%0d_remainder got %h want %h", i, h, e.hi); else passed++;
            checks++;
            if (div_zero !== e.dz) $display("FAIL div%0d_div_zero got %b want %b", i, div_zero, e.dz); else passed++;
        end
    endtask

    task automatic test_div_zero;
        logic [5:0]   fs[3];
        logic [W-1:0] as[3], ds[3], h, l;
        logic         st;
        int           lat;
        bit           to;
        exp_t         e;
        fs = '{FUNCT_DIV, FUNCT_DIVU, FUNCT_DIVU};
        as = '{32'd5, 32'hFFFFFF00, 32'd9};
        ds = '{32'd0, 32'd0, 32'd3};
        for (int i = 0; i < 3; i++) begin
            issue(fs[i], as[i], ds[i]);
            wait_done(lat, to);
            read_hilo(h, l, st);
            e = sb.pop_front();
            checks++;
            if (to || (ds[i] == '0 ? lat > 3 : lat != 34))
                $display("FAIL dz%0d_latency got %0d (timeout=%0b) want %s", i, lat, to, ds[i] == '0 ? "<=3" : "34");
            else passed++;
            checks++;
            if (l !== e.lo) $display("FAIL dz%0d_lo got %h want %h", i, l, e.lo); else passed++;
            checks++;
            if (h !== e.hi) $display("FAIL dz%0d_hi got %h want %h", i, h, e.hi); else passed++;
            checks++;
            if (div_zero !== e.dz) $display("FAIL dz%0d_flag got %b want %b", i, div_zero, e.dz); else passed++;
        end
    endtask

    task automatic test_stall;
        int   lat;
        logic stall_bad, seen_done, nonmd_stall;
        exp_t e;
        issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        lat = 1; stall_bad = 1'b0; seen_done = 1'b0; nonmd_stall = 1'b1;
        while (lat < 60) begin
            @(negedge clk);
            if (lat == 3) begin
                valid = 1'b1; funct = 6'h20; #1;
                nonmd_stall = stall;
                valid = 1'b0; funct = 6'h00;
            end
            if (lat == 5) begin valid = 1'b1; funct = FUNCT_MFHI; #1; end
            if (done) seen_done = 1'b1;
            if (!busy) break;
            if (lat >= 5 && stall !== 1'b1) stall_bad = 1'b1;
            @(posedge clk);
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (nonmd_stall !== 1'b0) $display("FAIL stall_nonmuldiv got %b want 0", nonmd_stall); else passed++;
        checks++;
        if (stall_bad !== 1'b0) $display("FAIL stall_while_busy got low-stall=%b want 0", stall_bad); else passed++;
        checks++;
        if (seen_done !== 1'b1 || lat != 35) $display("FAIL stall_release got done=%b at %0d want done=1 at 35", seen_done, lat);
        else passed++;
        checks++;
        if (stall !== 1'b0 || mf_data !== e.hi) $display("FAIL stall_mfhi got stall=%b data=%h want 0 %h", stall, mf_data, e.hi);
        else passed++;
        funct = FUNCT_MFLO; #1;
        checks++;
        if (mf_data !== e.lo) $display("FAIL stall_mflo got %h want %h", mf_data, e.lo); else passed++;
        valid = 1'b0; funct = 6'h00;
    endtask

    task automatic test_back_to_back;
        int           lat;
        bit           to;
        exp_t         e1, e2;
        logic [W-1:0] h, l;
        logic         st;
        issue(FUNCT_DIVU, 32'd1000, 32'd10);
        valid = 1'b1; funct = FUNCT_MULT; reg1 = 32'hFFFFFFFB; reg2 = 32'd6;
        e2 = model(FUNCT_MULT, reg1, reg2, dz_model);
        sb.push_back(e2);
        #1;
        checks++;
        if (stall !== 1'b1) $display("FAIL b2b_stall got %b want 1", stall); else passed++;
        wait_done(lat, to);
        checks++;
        if (to) $display("FAIL b2b_first_done got timeout at %0d want done", lat); else passed++;
        @(posedge clk);
        @(negedge clk);
        e1 = sb.pop_front();
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || mf_data !== e1.lo)
            $display("FAIL b2b_idle got busy=%b stall=%b lo=%h want 0 0 %h", busy, stall, mf_data, e1.lo);
        else passed++;
        @(posedge clk); #1;
        valid = 1'b0; funct = 6'h00;
        wait_done(lat, to);
        read_hilo(h, l, st);
        e2 = sb.pop_front();
        checks++;
        if (to || h !== e2.hi || l !== e2.lo)
            $display("FAIL b2b_second got %h_%h (timeout=%0b) want %h_%h", h, l, to, e2.hi, e2.lo);
        else passed++;
    endtask

    task automatic test_flush;
        logic [W-1:0] h, l;
        logic         st, saw_done;
        int           lat;
        bit           to;
        exp_t         e;
        @(negedge clk);
        valid = 1'b1; funct = FUNCT_MTLO; reg1 = 32'h1234;
        @(posedge clk); #1;
        funct = FUNCT_MTHI; reg1 = 32'h5678;
        @(posedge clk); #1;
        valid = 1'b0; funct = 6'h00;
        read_hilo(h, l, st);
        checks++;
        if (h !== 32'h5678 || l !== 32'h1234 || st !== 1'b0)
            $display("FAIL mt_write got %h_%h stall=%b want 00005678_00001234 0", h, l, st);
        else passed++;
        @(negedge clk);
        valid = 1'b1; funct = FUNCT_MULT; reg1 = 32'd2; reg2 = 32'd3; flush = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0; funct = 6'h00;
        checks++;
        if (busy !== 1'b0) $display("FAIL flush_idle_start got busy=%b want 0", busy); else passed++;
        // multiplier with a high bit set keeps the operation in CALC past cycle 10 in every build
        @(negedge clk);
        valid = 1'b1; funct = FUNCT_MULT; reg1 = 32'd2; reg2 = 32'h40000003;
        @(posedge clk); #1;
        valid = 1'b0; funct = 6'h00;
        saw_done = 1'b0;
        repeat (8) begin @(negedge clk); saw_done |= done; end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL flush_pre_busy got %b want 1", busy); else passed++;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (5) begin @(negedge clk); saw_done |= done; end
        checks++;
        if (saw_done !== 1'b0 || busy !== 1'b0) $display("FAIL flush_calc got done=%b busy=%b want 0 0", saw_done, busy);
        else passed++;
        read_hilo(h, l, st);
        checks++;
        if (h !== 32'h5678 || l !== 32'h1234) $display("FAIL flush_hilo got %h_%h want 00005678_00001234", h, l);
        else passed++;
        issue(FUNCT_DIVU, 32'd50, 32'd5);
        wait_done(lat, to);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        read_hilo(h, l, st);
        e = sb.pop_front();
        checks++;
        if (to || h !== e.hi || l !== e.lo) $display("FAIL flush_done got %h_%h want %h_%h", h, l, e.hi, e.lo);
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] h, l;
        logic         st;
        int           lat;
        bit           to;
        exp_t         e;
        issue(FUNCT_DIV, 32'd77, 32'd0);
        wait_done(lat, to);
        read_hilo(h, l, st);
        e = sb.pop_front();
        checks++;
        if (div_zero !== e.dz || l !== e.lo) $display("FAIL rst_pre_dz got dz=%b lo=%h want %b %h", div_zero, l, e.dz, e.lo);
        else passed++;
        @(negedge clk);
        valid = 1'b1; funct = FUNCT_DIV; reg1 = 32'd1000; reg2 = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0; funct = 6'h00;
        repeat (18) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL rst_pre_busy got %b want 1", busy); else passed++;
        valid = 1'b1; funct = FUNCT_MFHI;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, stall, done, div_zero} !== 4'b0) $display("FAIL rst_mid_flags got %b want 0000", {busy, stall, done, div_zero});
        else passed++;
        checks++;
        if (mf_data !== '0) $display("FAIL rst_mid_hi got %h want 0", mf_data); else passed++;
        funct = FUNCT_MFLO; #1;
        checks++;
        if (mf_data !== '0) $display("FAIL rst_mid_lo got %h want 0", mf_data); else passed++;
        @(negedge clk);
        valid = 1'b0; funct = 6'h00; reset = 1'b1;
        dz_model = 1'b0;
    endtask

    task automatic test_early_out;
        logic [5:0]   fs[3];
        logic [W-1:0] as[3], ds[3], h, l;
        int           want[3];
        logic         st;
        int           lat;
        bit           to;
        exp_t         e;
        fs = '{FUNCT_MULTU, FUNCT_MULTU, FUNCT_MULT};
        as = '{32'h0000ABCD, 32'h00001234, 32'hFFFFFFF9};
        ds = '{32'd1, 32'd0, 32'h00000100};
`ifdef MULDIV_EARLY_OUT_EN
        want = '{4, 3, 12};
`else
        want = '{34, 34, 34};
`endif
        for (int i = 0; i < 3; i++) begin
            issue(fs[i], as[i], ds[i]);
            wait_done(lat, to);
            read_hilo(h, l, st);
            e = sb.pop_front();
            checks++;
            if (to || lat != want[i]) $display("FAIL eo%0d_latency got %0d (timeout=%0b) want %0d", i, lat, to, want[i]);
            else passed++;
            checks++;
            if (h !== e.hi || l !== e.lo) $display("FAIL eo%0d_product got %h_%h want %h_%h", i, h, l, e.hi, e.lo);
            else passed++;
        end
    endtask

    initial begin
        checks = 0; passed = 0; dz_model = 1'b0;
        reset = 1'b0; valid = 1'b0; flush = 1'b0; funct = 6'h00; reg1 = '0; reg2 = '0;
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_stall;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_early_out;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1);
    end

endmodule
